// File: rtl/i2c_slave_responder.sv
// -----------------------------------------------------------------------------
// i2c_slave_responder
//
// I2C slave endpoint with a fixed 7-bit address. SCL and SDA are oversampled
// by clk_i, so clk_i must run at least 10x the SCL frequency. The slave
// acknowledges its own address, hands every written byte to the user logic,
// and fetches read bytes from the user logic. It never stretches SCL.
//
// Ports
//   clk_i        system clock
//   rst_i        asynchronous active-low reset
//   scl_s        I2C clock (input only)
//   sda_s        I2C data, open drain (driven 0 or Z)
//   start_o      one-cycle pulse on START / repeated START
//   stop_o       one-cycle pulse on STOP
//   dir_o        R/W bit of the last matched address (1 = read)
//   addressed_o  high from the address ACK until the next START/STOP
//   wr_data_o    last received write byte
//   wr_valid_o   one-cycle pulse when wr_data_o updates
//   rd_req_o     one-cycle pulse requesting the next read byte
//   rd_data_i    read byte, sampled the cycle after rd_req_o
//   mst_ack_o    master ACK bit after the last read byte (1 = ACK)
// -----------------------------------------------------------------------------
module i2c_slave_responder #(
  parameter int                        I2C_ADDR_WIDTH = 7,
  parameter int                        I2C_DATA_WIDTH = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDRESS  = 7'h22
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      scl_s,
  inout  wire                       sda_s,
  output logic                      start_o,
  output logic                      stop_o,
  output logic                      dir_o,
  output logic                      addressed_o,
  output logic [I2C_DATA_WIDTH-1:0] wr_data_o,
  output logic                      wr_valid_o,
  output logic                      rd_req_o,
  input  logic [I2C_DATA_WIDTH-1:0] rd_data_i,
  output logic                      mst_ack_o
);

  localparam int CNT_W = $clog2(I2C_DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(I2C_ADDR_WIDTH);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(I2C_DATA_WIDTH - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ADDR      = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
  localparam logic [2:0] ST_WRITE     = 3'd3;
  localparam logic [2:0] ST_WRITE_ACK = 3'd4;
  localparam logic [2:0] ST_READ      = 3'd5;
  localparam logic [2:0] ST_READ_ACK  = 3'd6;
  localparam logic [2:0] ST_IGNORE    = 3'd7;

  // ---------------------------------------------------------------------------
  // Input synchronisers plus one register of history for edge detection.
  // They reset to 1 (idle bus) so leaving reset never fakes a START/STOP.
  // ---------------------------------------------------------------------------
  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_prev_q, sda_prev_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_s};
      sda_sync_q <= {sda_sync_q[0], sda_s};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  logic scl_now, sda_now;
  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_now   = scl_sync_q[1];
  assign sda_now   = sda_sync_q[1];
  assign scl_rise  =  scl_now & ~scl_prev_q;
  assign scl_fall  = ~scl_now &  scl_prev_q;
  assign start_det =  scl_now &  scl_prev_q &  sda_prev_q & ~sda_now;
  assign stop_det  =  scl_now &  scl_prev_q & ~sda_prev_q &  sda_now;

  // ---------------------------------------------------------------------------
  // Protocol FSM
  // ---------------------------------------------------------------------------
  logic [2:0]                state_q,     state_d;
  logic [CNT_W-1:0]          bit_cnt_q,   bit_cnt_d;
  logic [I2C_DATA_WIDTH-1:0] shift_q,     shift_d;
  logic [I2C_DATA_WIDTH-1:0] wr_data_q,   wr_data_d;
  logic                      dir_q,       dir_d;
  logic                      addressed_q, addressed_d;
  logic                      mst_ack_q,   mst_ack_d;
  logic                      sda_drive_q, sda_drive_d;  // 1 = pull SDA low
  logic                      start_q,     start_d;
  logic                      stop_q,      stop_d;
  logic                      wr_valid_q,  wr_valid_d;
  logic                      rd_req_q,    rd_req_d;
  logic                      rd_load_q;                 // cycle after rd_req_o

  logic [I2C_DATA_WIDTH-1:0] shift_in;
  assign shift_in = {shift_q[I2C_DATA_WIDTH-2:0], sda_now};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    wr_data_d   = wr_data_q;
    dir_d       = dir_q;
    addressed_d = addressed_q;
    mst_ack_d   = mst_ack_q;
    sda_drive_d = sda_drive_q;
    start_d     = 1'b0;
    stop_d      = 1'b0;
    wr_valid_d  = 1'b0;
    rd_req_d    = 1'b0;

    if (start_det) begin
      state_d     = ST_ADDR;
      bit_cnt_d   = '0;
      sda_drive_d = 1'b0;
      addressed_d = 1'b0;
      start_d     = 1'b1;
    end else if (stop_det) begin
      state_d     = ST_IDLE;
      sda_drive_d = 1'b0;
      addressed_d = 1'b0;
      stop_d      = 1'b1;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d = shift_in;
            if (bit_cnt_q == ADDR_LAST) begin
              // shift_q already holds the address bits; sda_now is R/W.
              bit_cnt_d = '0;
              if (shift_q[I2C_ADDR_WIDTH-1:0] == SLAVE_ADDRESS) begin
                state_d = ST_ADDR_ACK;
                dir_d   = sda_now;
              end else begin
                state_d = ST_IGNORE;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_ONE;
            end
          end
        end

        // In both ACK states the drive flag doubles as the phase marker:
        // the first fall starts pulling SDA low, the second ends the ACK.
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_drive_q) begin
              sda_drive_d = 1'b1;
              addressed_d = 1'b1;
            end else begin
              bit_cnt_d = '0;
              if (dir_q) begin
                // Keep holding SDA until the fetched byte sets the MSB level.
                state_d  = ST_READ;
                rd_req_d = 1'b1;
              end else begin
                state_d     = ST_WRITE;
                sda_drive_d = 1'b0;
              end
            end
          end
        end

        ST_WRITE: begin
          if (scl_rise) begin
            shift_d = shift_in;
            if (bit_cnt_q == DATA_LAST) begin
              wr_data_d  = shift_in;
              wr_valid_d = 1'b1;
              bit_cnt_d  = '0;
              state_d    = ST_WRITE_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_ONE;
            end
          end
        end

        ST_WRITE_ACK: begin
          if (scl_fall) begin
            if (!sda_drive_q) begin
              sda_drive_d = 1'b1;
            end else begin
              sda_drive_d = 1'b0;
              bit_cnt_d   = '0;
              state_d     = ST_WRITE;
            end
          end
        end

        ST_READ: begin
          if (rd_load_q) begin
            // Fetched byte arrives while SCL is still low: put its MSB out.
            shift_d     = rd_data_i;
            sda_drive_d = ~rd_data_i[I2C_DATA_WIDTH-1];
            bit_cnt_d   = '0;
          end else if (scl_fall) begin
            if (bit_cnt_q == DATA_LAST) begin
              sda_drive_d = 1'b0;
              bit_cnt_d   = '0;
              state_d     = ST_READ_ACK;
            end else begin
              shift_d     = {shift_q[I2C_DATA_WIDTH-2:0], 1'b0};
              sda_drive_d = ~shift_q[I2C_DATA_WIDTH-2];
              bit_cnt_d   = bit_cnt_q + CNT_ONE;
            end
          end
        end

        // bit_cnt_q == 1 marks "master ACKed, fetch next byte at the fall".
        ST_READ_ACK: begin
          if (scl_rise) begin
            mst_ack_d = ~sda_now;
            if (sda_now) begin
              state_d = ST_IGNORE;
            end else begin
              bit_cnt_d = CNT_ONE;
            end
          end else if (scl_fall && (bit_cnt_q == CNT_ONE)) begin
            state_d   = ST_READ;
            rd_req_d  = 1'b1;
            bit_cnt_d = '0;
          end
        end

        default: begin
          // ST_IDLE and ST_IGNORE wait for START/STOP only.
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      wr_data_q   <= '0;
      dir_q       <= 1'b0;
      addressed_q <= 1'b0;
      mst_ack_q   <= 1'b0;
      sda_drive_q <= 1'b0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      wr_valid_q  <= 1'b0;
      rd_req_q    <= 1'b0;
      rd_load_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      wr_data_q   <= wr_data_d;
      dir_q       <= dir_d;
      addressed_q <= addressed_d;
      mst_ack_q   <= mst_ack_d;
      sda_drive_q <= sda_drive_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      wr_valid_q  <= wr_valid_d;
      rd_req_q    <= rd_req_d;
      rd_load_q   <= rd_req_q;
    end
  end

  assign sda_s       = sda_drive_q ? 1'b0 : 1'bz;
  assign start_o     = start_q;
  assign stop_o      = stop_q;
  assign dir_o       = dir_q;
  assign addressed_o = addressed_q;
  assign wr_data_o   = wr_data_q;
  assign wr_valid_o  = wr_valid_q;
  assign rd_req_o    = rd_req_q;
  assign mst_ack_o   = mst_ack_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// -----------------------------------------------------------------------------
// tb_i2c_slave_responder
//
// Directed bench: a bit-banged I2C master drives SCL/SDA (SDA open drain with
// a pull-up), monitors count the DUT pulses, and immediate assertions compare
// observed values with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_i2c_slave_responder;

  localparam int Q = 8;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m_low = 1'b0;
  logic [7:0] rd_data_i = 8'h00;

  wire        sda_bus;
  logic       start_o, stop_o, dir_o, addressed_o, wr_valid_o, rd_req_o, mst_ack_o;
  logic [7:0] wr_data_o;

  pullup (sda_bus);
  assign sda_bus = sda_m_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_slave_responder dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .scl_s       (scl),
    .sda_s       (sda_bus),
    .start_o     (start_o),
    .stop_o      (stop_o),
    .dir_o       (dir_o),
    .addressed_o (addressed_o),
    .wr_data_o   (wr_data_o),
    .wr_valid_o  (wr_valid_o),
    .rd_req_o    (rd_req_o),
    .rd_data_i   (rd_data_i),
    .mst_ack_o   (mst_ack_o)
  );

  // ---------------- monitors (sampled on the inactive edge) ----------------
  int         start_cnt = 0, stop_cnt = 0, wr_cnt = 0, rd_cnt = 0, drive_cnt = 0;
  logic [7:0] wr_log [0:15];

  always @(negedge clk) begin
    if (start_o) start_cnt <= start_cnt + 1;
    if (stop_o)  stop_cnt  <= stop_cnt + 1;
    if (rd_req_o) rd_cnt   <= rd_cnt + 1;
    if (wr_valid_o && wr_cnt < 16) begin
      wr_log[wr_cnt] <= wr_data_o;
      wr_cnt         <= wr_cnt + 1;
    end
    // Bus low while the master is not pulling means the slave is driving.
    if (sda_bus === 1'b0 && !sda_m_low) drive_cnt <= drive_cnt + 1;
  end

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- bit-banged master ----------------
  task automatic wait_q();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic send_start();
    sda_m_low = 1'b0; wait_q();
    scl = 1'b1;       wait_q();
    sda_m_low = 1'b1; wait_q();
    scl = 1'b0;       wait_q();
  endtask

  task automatic send_stop();
    sda_m_low = 1'b1; wait_q();
    scl = 1'b1;       wait_q();
    sda_m_low = 1'b0; wait_q();
  endtask

  task automatic clock_bit(input logic b, output logic s);
    sda_m_low = ~b; wait_q();
    scl = 1'b1;     wait_q();
    s = sda_bus;    wait_q();
    scl = 1'b0;     wait_q();
  endtask

  // ack = level seen on the ninth clock (0 means the slave acknowledged)
  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      d[i] = s;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic       ack, s;
    logic [7:0] rbyte;
    int         st0, sp0, wr0, rd0, dr0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_sda",       sda_bus,     1'b1);
    check("rst_start",     start_o,     1'b0);
    check("rst_stop",      stop_o,      1'b0);
    check("rst_wr_valid",  wr_valid_o,  1'b0);
    check("rst_rd_req",    rd_req_o,    1'b0);
    check("rst_wr_data",   wr_data_o,   8'h00);
    check("rst_dir",       dir_o,       1'b0);
    check("rst_addressed", addressed_o, 1'b0);
    check("rst_mst_ack",   mst_ack_o,   1'b0);
    rst_i = 1'b1;
    wait_q();

    // 1: write 0x00, 0x7F, 0xFF to 0x22
    st0 = start_cnt; sp0 = stop_cnt; wr0 = wr_cnt;
    send_start();
    write_byte(8'h44, ack); check("t1_addr_ack", ack, 1'b0);
    check("t1_addressed", addressed_o, 1'b1);
    check("t1_dir", dir_o, 1'b0);
    write_byte(8'h00, ack); check("t1_ack_b0", ack, 1'b0);
    write_byte(8'h7F, ack); check("t1_ack_b1", ack, 1'b0);
    write_byte(8'hFF, ack); check("t1_ack_b2", ack, 1'b0);
    send_stop();
    wait_q();
    check("t1_wr_count", wr_cnt - wr0, 3);
    check("t1_wr0", wr_log[wr0],     8'h00);
    check("t1_wr1", wr_log[wr0 + 1], 8'h7F);
    check("t1_wr2", wr_log[wr0 + 2], 8'hFF);
    check("t1_wr_data_last", wr_data_o, 8'hFF);
    check("t1_starts", start_cnt - st0, 1);
    check("t1_stops",  stop_cnt - sp0,  1);
    check("t1_addressed_after_stop", addressed_o, 1'b0);
    $display("txn write 0x22: 00 7F FF");

    // 2: address 0x23 is ignored
    wr0 = wr_cnt; dr0 = drive_cnt;
    send_start();
    write_byte(8'h46, ack); check("t2_addr_nack", ack, 1'b1);
    check("t2_addressed", addressed_o, 1'b0);
    write_byte(8'h12, ack); check("t2_data_nack", ack, 1'b1);
    send_stop();
    wait_q();
    check("t2_no_drive", drive_cnt - dr0, 0);
    check("t2_no_write", wr_cnt - wr0, 0);
    $display("txn write 0x23: ignored");

    // 3: read A5 (ACK) then 3C (NACK) from 0x22
    rd0 = rd_cnt;
    rd_data_i = 8'hA5;
    send_start();
    write_byte(8'h45, ack); check("t3_addr_ack", ack, 1'b0);
    check("t3_dir", dir_o, 1'b1);
    read_byte(rbyte); check("t3_rd0", rbyte, 8'hA5);
    rd_data_i = 8'h3C;
    clock_bit(1'b0, s);
    check("t3_mst_ack_1", mst_ack_o, 1'b1);
    read_byte(rbyte); check("t3_rd1", rbyte, 8'h3C);
    rd_data_i = 8'hEE;
    clock_bit(1'b1, s);
    check("t3_mst_ack_0", mst_ack_o, 1'b0);
    dr0 = drive_cnt;
    wait_q();
    check("t3_released", sda_bus, 1'b1);
    send_stop();
    wait_q();
    check("t3_no_drive_after_nack", drive_cnt - dr0, 0);
    check("t3_rd_req_count", rd_cnt - rd0, 2);
    $display("txn read 0x22: A5 3C");

    // 4: write 0x55, repeated START, read 0x81
    st0 = start_cnt; wr0 = wr_cnt;
    rd_data_i = 8'h81;
    send_start();
    write_byte(8'h44, ack); check("t4_waddr_ack", ack, 1'b0);
    write_byte(8'h55, ack); check("t4_wdata_ack", ack, 1'b0);
    check("t4_dir_w", dir_o, 1'b0);
    send_start();
    write_byte(8'h45, ack); check("t4_raddr_ack", ack, 1'b0);
    check("t4_dir_r", dir_o, 1'b1);
    read_byte(rbyte); check("t4_rd", rbyte, 8'h81);
    clock_bit(1'b1, s);
    send_stop();
    wait_q();
    check("t4_starts", start_cnt - st0, 2);
    check("t4_wr_count", wr_cnt - wr0, 1);
    check("t4_wr_val", wr_log[wr0], 8'h55);
    $display("txn write 0x55 / rs / read 0x81");

    // 5: reset during 4th data bit of a write, then a fresh transfer
    wr0 = wr_cnt;
    send_start();
    write_byte(8'h44, ack); check("t5_addr_ack", ack, 1'b0);
    check("t5_addressed_pre", addressed_o, 1'b1);
    clock_bit(1'b1, s); clock_bit(1'b1, s); clock_bit(1'b1, s);
    sda_m_low = 1'b0; wait_q();
    scl = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_i = 1'b0;
    #1;
    check("t5_rst_sda", sda_bus, 1'b1);
    check("t5_rst_addressed", addressed_o, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b1;
    wait_q();
    scl = 1'b0; wait_q();
    send_stop();
    send_start();
    write_byte(8'h44, ack); check("t5_fresh_addr_ack", ack, 1'b0);
    write_byte(8'h5A, ack); check("t5_fresh_data_ack", ack, 1'b0);
    send_stop();
    wait_q();
    check("t5_wr_count", wr_cnt - wr0, 1);
    check("t5_wr_val", wr_log[wr0], 8'h5A);
    $display("txn reset mid-write, then write 0x5A");

    // 6: START then STOP with no bits
    st0 = start_cnt; sp0 = stop_cnt; wr0 = wr_cnt; dr0 = drive_cnt;
    send_start();
    send_stop();
    wait_q();
    check("t6_starts",   start_cnt - st0, 1);
    check("t6_stops",    stop_cnt - sp0,  1);
    check("t6_no_drive", drive_cnt - dr0, 0);
    check("t6_no_write", wr_cnt - wr0,    0);
    $display("txn start/stop only");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
